// File: rtl/mul64_seq_ctrl.sv
// 64x64 unsigned multiply controller that time-shares one external 32x32 multiplier.
// Runs four partial products in sequence and accumulates them into a 128-bit result.
module mul64_seq_ctrl #(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  a,
   input  logic [63:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] result,
   output logic [31:0]  pp_a,
   output logic [31:0]  pp_b,
   input  logic [63:0]  pp_prod,
   output logic         busy
);

   localparam int unsigned CNT_W  = 2;
   localparam int unsigned PASS_W = 2;
   localparam int unsigned ACC_W  = 128;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [63:0]         op_a_q, op_a_d;
   logic [63:0]         op_b_q, op_b_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                in_ready_d, out_valid_d, busy_d;
   logic [ACC_W-1:0]    result_d;
   logic [31:0]         pp_a_d, pp_b_d;
   logic [6:0]          shift;
   logic [ACC_W-1:0]    sum;
   logic [PASS_W-1:0]   pass_nxt;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_a_q    <= '0;
         op_b_q    <= '0;
         acc_q     <= '0;
         pass_q    <= '0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         pp_a      <= '0;
         pp_b      <= '0;
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         acc_q     <= acc_d;
         pass_q    <= pass_d;
         cnt_q     <= cnt_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
         result    <= result_d;
         pp_a      <= pp_a_d;
         pp_b      <= pp_b_d;
      end
   end

   // Next-state, accumulate and operand sequencing
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      acc_d       = acc_q;
      pass_d      = pass_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;
      busy_d      = busy;
      result_d    = result;
      pp_a_d      = pp_a;
      pp_b_d      = pp_b;
      pass_nxt    = pass_q + PASS_W'(1);

      // Pass 0 is unshifted, pass 3 lands at bit 64, the cross terms at bit 32
      case (pass_q)
         2'd0:    shift = 7'd0;
         2'd3:    shift = 7'd64;
         default: shift = 7'd32;
      endcase
      sum = acc_q + (ACC_W'(pp_prod) << shift);

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_a_d     = a;
               op_b_d     = b;
               acc_d      = '0;
               pass_d     = '0;
               cnt_d      = '0;
               pp_a_d     = a[31:0];
               pp_b_d     = b[31:0];
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(MUL_LAT)) begin
               acc_d  = sum;
               cnt_d  = '0;
               pass_d = pass_nxt;
               if (pass_q == 2'd3) begin
                  result_d    = sum;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  // bit1 of the pass selects the high half of a, bit0 the high half of b
                  pp_a_d = pass_nxt[1] ? op_a_q[63:32] : op_a_q[31:0];
                  pp_b_d = pass_nxt[0] ? op_b_q[63:32] : op_b_q[31:0];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mul64_seq_ctrl.sv
// Bench for mul64_seq_ctrl: one instance per MUL_LAT value 0..3, each with its own
// behavioural 32x32 multiplier, checked against plain 128-bit arithmetic.
module tb_mul64_seq_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [4];
   logic         in_ready  [4];
   logic [63:0]  a         [4];
   logic [63:0]  b         [4];
   logic         out_valid [4];
   logic         out_ready [4];
   logic [127:0] result    [4];
   logic [31:0]  pp_a      [4];
   logic [31:0]  pp_b      [4];
   logic [63:0]  pp_prod   [4];
   logic         busy      [4];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_lat
      logic [63:0] pipe [3];

      mul64_seq_ctrl #(.MUL_LAT(g)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a[g]),
         .b         (b[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .result    (result[g]),
         .pp_a      (pp_a[g]),
         .pp_b      (pp_b[g]),
         .pp_prod   (pp_prod[g]),
         .busy      (busy[g])
      );

      // External multiplier: g register stages, or purely combinational for g==0
      always @(posedge clk) begin
         pipe[0] <= 64'(pp_a[g]) * 64'(pp_b[g]);
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      if (g == 0) begin : g_comb
         assign pp_prod[g] = 64'(pp_a[g]) * 64'(pp_b[g]);
      end else begin : g_pipe
         assign pp_prod[g] = pipe[g-1];
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Operand halves expected on the shared multiplier during pass p
   function automatic logic [63:0] pp_exp(input logic [63:0] av, input logic [63:0] bv,
                                          input int p);
      logic [31:0] ah, bh;
      ah = (p >= 2) ? av[63:32] : av[31:0];
      bh = (p % 2 == 1) ? bv[63:32] : bv[31:0];
      return {ah, bh};
   endfunction

   task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input logic [127:0] exp_res, input int hold, input bit noise);
      int lat;
      int cyc;
      lat = 4 * (k + 1);
      cyc = 0;
      @(negedge clk);
      check("in_ready_idle", 128'(in_ready[k]), 128'd1);
      in_valid[k] = 1'b1;
      a[k] = av;
      b[k] = bv;
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      while (!out_valid[k] && cyc <= lat + 4) begin
         check("busy_run", 128'(busy[k]), 128'd1);
         check("in_ready_run", 128'(in_ready[k]), 128'd0);
         if (cyc < lat)
            check("pp_operands", 128'({pp_a[k], pp_b[k]}), 128'(pp_exp(av, bv, cyc / (k + 1))));
         if (noise) begin
            in_valid[k] = 1'($urandom);
            a[k] = {$urandom, $urandom};
            b[k] = {$urandom, $urandom};
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      in_valid[k] = 1'b0;
      check("latency", 128'(cyc), 128'(lat));
      if (!out_valid[k]) return;
      for (int i = 0; i < hold; i++) begin
         check("out_valid_hold", 128'(out_valid[k]), 128'd1);
         check("result_hold", result[k], exp_res);
         check("in_ready_done", 128'(in_ready[k]), 128'd0);
         check("busy_done", 128'(busy[k]), 128'd1);
         @(negedge clk);
      end
      check("result", result[k], exp_res);
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      check("out_valid_clr", 128'(out_valid[k]), 128'd0);
      check("in_ready_back", 128'(in_ready[k]), 128'd1);
      check("busy_clr", 128'(busy[k]), 128'd0);
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'd0;
         2:       return {32'd0, $urandom};
         3:       return {$urandom, 32'd0};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] av, bv;
      int k;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         a[i]         = '0;
         b[i]         = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rst_in_ready", 128'(in_ready[i]), 128'd1);
         check("rst_out_valid", 128'(out_valid[i]), 128'd0);
         check("rst_busy", 128'(busy[i]), 128'd0);
         check("rst_result", result[i], 128'd0);
         check("rst_pp", 128'({pp_a[i], pp_b[i]}), 128'd0);
      end
      rst = 1'b0;

      run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             128'hFFFFFFFFFFFFFFFE_0000000000000001, 2, 1'b0);
      run_op(0, 64'h1_0000_0000, 64'h1_0000_0000, 128'h0000000000000001_0000000000000000, 1, 1'b0);
      run_op(0, 64'd3, 64'd5, 128'd15, 0, 1'b0);
      run_op(1, 64'd7, 64'd9, 128'd63, 10, 1'b0);
      run_op(2, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444,
             128'(64'hAAAA_BBBB_CCCC_DDDD) * 128'(64'h1111_2222_3333_4444), 1, 1'b1);
      run_op(3, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444,
             128'(64'hAAAA_BBBB_CCCC_DDDD) * 128'(64'h1111_2222_3333_4444), 3, 1'b1);

      // Abort an operation during its third pass
      @(negedge clk);
      in_valid[1] = 1'b1;
      a[1] = 64'h1234_5678_9ABC_DEF0;
      b[1] = 64'h0FED_CBA9_8765_4321;
      @(posedge clk);
      @(negedge clk);
      in_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      check("midop_pass2_pp", 128'({pp_a[1], pp_b[1]}), 128'({32'h1234_5678, 32'h8765_4321}));
      #2 rst = 1'b1;
      #1;
      check("midop_out_valid", 128'(out_valid[1]), 128'd0);
      check("midop_in_ready", 128'(in_ready[1]), 128'd1);
      check("midop_result", result[1], 128'd0);
      check("midop_busy", 128'(busy[1]), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_out_valid", 128'(out_valid[1]), 128'd0);
      run_op(1, 64'd2, 64'd3, 128'd6, 1, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         k  = $urandom_range(0, 3);
         av = pick_operand();
         bv = pick_operand();
         run_op(k, av, bv, 128'(av) * 128'(bv), $urandom_range(0, 3), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
